pipeline_hazard_ctrl: RTL and testbench

//  Next-gen 5-stage pipeline control: advances IF/ID, ID/EX, EX/MEM, MEM/WB.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_types (package)
//  Purpose  : Shared types for the pipeline hazard controller.
//             hzd_state_t - control FSM states (BOOT, ACCESS)
//             fwd_sel_t   - operand forwarding select encoding
//  Revision : 1.0 - initial release
// ============================================================================
package rv32i_types;

   typedef enum logic [0:0] {
      BOOT   = 1'b0,
      ACCESS = 1'b1
   } hzd_state_t;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Saturating up-counter; holds at all-ones.
//  Ports    : clk, rst (async active-high), inc (count enable),
//             count [W-1:0] (current value)
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);
   import rv32i_types::*;

   localparam logic [W-1:0] c_MAX = {W{1'b1}};
   localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && (r_count != c_MAX)) begin
         r_count <= r_count + c_ONE;
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : 5-stage pipeline control. Joins the split I-mem/D-mem
//             handshakes into one advance strobe, detects load-use and
//             (without forwarding) RAW hazards, flushes wrong-path work on
//             EX redirects, drives forwarding selects and perf counters.
//  Ports    : clk, rst                      clock, async active-high reset
//             imem_resp, dmem_resp          memory completion pulses
//             id_rs1/2, id_use_rs1/2        IF/ID source operands
//             ex_rs1/2, ex_rd, ex_we,
//             ex_is_load, ex_redirect       ID/EX instruction info
//             mem_rd, mem_we, mem_is_load,
//             mem_is_store                  EX/MEM instruction info
//             wb_rd, wb_we                  MEM/WB instruction info
//             advance, hold_front,
//             bubble_idex, flush_ifid,
//             pcmux_redirect                pipeline buffer controls
//             imem_read, dmem_read,
//             dmem_write                    memory requests
//             fwd_a, fwd_b                  forwarding selects
//             stall_cnt, flush_cnt          saturating perf counters
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int REG_W  = 5,
   parameter int PERF_W = 32,
   parameter bit FWD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_resp,
   input  logic              dmem_resp,
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_W-1:0]  ex_rs1,
   input  logic [REG_W-1:0]  ex_rs2,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_we,
   input  logic              ex_is_load,
   input  logic              ex_redirect,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic              mem_we,
   input  logic              mem_is_load,
   input  logic              mem_is_store,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic              wb_we,
   output logic              advance,
   output logic              hold_front,
   output logic              bubble_idex,
   output logic              flush_ifid,
   output logic              pcmux_redirect,
   output logic              imem_read,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
);
   import rv32i_types::*;

   localparam logic [REG_W-1:0] c_X0 = '0;

   // True when the IF/ID instruction actually reads register rd (x0 never counts).
   function automatic logic id_reads(
      input logic [REG_W-1:0] rd,
      input logic [REG_W-1:0] rs1,
      input logic [REG_W-1:0] rs2,
      input logic             use1,
      input logic             use2
   );
      return (rd != c_X0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
   endfunction

   // EX/MEM is the younger producer, so it wins over MEM/WB.
   function automatic fwd_sel_t fwd_pick(
      input logic [REG_W-1:0] rs,
      input logic [REG_W-1:0] m_rd,
      input logic             m_we,
      input logic [REG_W-1:0] w_rd,
      input logic             w_we
   );
      if (m_we && (m_rd != c_X0) && (m_rd == rs)) begin
         return FWD_EXMEM;
      end else if (w_we && (w_rd != c_X0) && (w_rd == rs)) begin
         return FWD_MEMWB;
      end
      return FWD_RF;
   endfunction

   hzd_state_t r_state;
   logic       r_i_done;
   logic       r_d_done;

   logic       w_access;
   logic       w_i_ok;
   logic       w_d_ok;
   logic       w_load_use;
   logic       w_raw_hazard;
   logic       w_hazard;
   logic       w_stall_inc;
   logic       w_flush_inc;
   fwd_sel_t   w_fwd_a;
   fwd_sel_t   w_fwd_b;

   // ------------------------------------------------------------------------
   // Control FSM and response-seen flags. A response that arrives before the
   // other side is ready is remembered until the joint advance consumes it.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= BOOT;
         r_i_done <= 1'b0;
         r_d_done <= 1'b0;
      end else begin
         case (r_state)
            BOOT: begin
               r_state <= ACCESS;
            end
            ACCESS: begin
               if (advance) begin
                  r_i_done <= 1'b0;
                  r_d_done <= 1'b0;
               end else begin
                  if (imem_resp) r_i_done <= 1'b1;
                  if (dmem_resp) r_d_done <= 1'b1;
               end
            end
            default: begin
               r_state <= BOOT;
            end
         endcase
      end
   end

   assign w_access = (r_state == ACCESS);
   assign w_i_ok   = r_i_done | imem_resp;
   assign w_d_ok   = !(mem_is_load | mem_is_store) | r_d_done | dmem_resp;

   assign advance    = w_access & w_i_ok & w_d_ok;
   assign imem_read  = w_access & !r_i_done;
   assign dmem_read  = w_access & mem_is_load  & !r_d_done;
   assign dmem_write = w_access & mem_is_store & !r_d_done;

   // ------------------------------------------------------------------------
   // Hazard detection and forwarding
   // ------------------------------------------------------------------------
   assign w_load_use = ex_is_load & ex_we &
                       id_reads(ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);

   generate
      if (FWD_EN) begin : g_fwd
         assign w_raw_hazard = 1'b0;
         assign w_fwd_a      = fwd_pick(ex_rs1, mem_rd, mem_we, wb_rd, wb_we);
         assign w_fwd_b      = fwd_pick(ex_rs2, mem_rd, mem_we, wb_rd, wb_we);
      end else begin : g_no_fwd
         // Without bypass paths every in-flight producer blocks its consumer
         // until it has been written back.
         assign w_raw_hazard =
            (ex_we  & id_reads(ex_rd,  id_rs1, id_rs2, id_use_rs1, id_use_rs2)) |
            (mem_we & id_reads(mem_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2)) |
            (wb_we  & id_reads(wb_rd,  id_rs1, id_rs2, id_use_rs1, id_use_rs2));
         assign w_fwd_a = FWD_RF;
         assign w_fwd_b = FWD_RF;
      end
   endgenerate

   assign w_hazard = w_load_use | w_raw_hazard;

   // A redirect squashes the IF/ID consumer, so any hazard it had is moot.
   assign flush_ifid     = advance & ex_redirect;
   assign pcmux_redirect = advance & ex_redirect;
   assign hold_front     = advance & !ex_redirect & w_hazard;
   assign bubble_idex    = advance & (ex_redirect | w_hazard);

   // Forwarding selects are purely combinational from the datapath fields;
   // force them quiet while reset is held.
   assign fwd_a = rst ? FWD_RF : w_fwd_a;
   assign fwd_b = rst ? FWD_RF : w_fwd_b;

   // ------------------------------------------------------------------------
   // Perf counters
   // ------------------------------------------------------------------------
   assign w_stall_inc = w_access & (!advance | (w_hazard & !ex_redirect));
   assign w_flush_inc = advance & ex_redirect;

   sat_counter #(.W(PERF_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(PERF_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_flush_inc),
      .count (flush_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Directed self-checking bench. Two instances share stimulus:
//             dut (forwarding, 32-bit counters) and dut_nf (no forwarding,
//             4-bit counters so saturation is reachable).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       imem_resp, dmem_resp;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_use_rs1, id_use_rs2, ex_we, ex_is_load, ex_redirect;
   logic       mem_we, mem_is_load, mem_is_store, wb_we;

   logic        advance, hold_front, bubble_idex, flush_ifid, pcmux_redirect;
   logic        imem_read, dmem_read, dmem_write;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] stall_cnt, flush_cnt;

   logic        n_advance, n_hold_front, n_bubble_idex, n_flush_ifid, n_pcmux;
   logic        n_imem_read, n_dmem_read, n_dmem_write;
   logic [1:0]  n_fwd_a, n_fwd_b;
   logic [3:0]  n_stall_cnt, n_flush_cnt;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_W(5), .PERF_W(32), .FWD_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_we(ex_we),
      .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .mem_rd(mem_rd), .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
      .wb_rd(wb_rd), .wb_we(wb_we),
      .advance(advance), .hold_front(hold_front), .bubble_idex(bubble_idex),
      .flush_ifid(flush_ifid), .pcmux_redirect(pcmux_redirect),
      .imem_read(imem_read), .dmem_read(dmem_read), .dmem_write(dmem_write),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_ctrl #(.REG_W(5), .PERF_W(4), .FWD_EN(1'b0)) dut_nf (
      .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_we(ex_we),
      .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .mem_rd(mem_rd), .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
      .wb_rd(wb_rd), .wb_we(wb_we),
      .advance(n_advance), .hold_front(n_hold_front), .bubble_idex(n_bubble_idex),
      .flush_ifid(n_flush_ifid), .pcmux_redirect(n_pcmux),
      .imem_read(n_imem_read), .dmem_read(n_dmem_read), .dmem_write(n_dmem_write),
      .fwd_a(n_fwd_a), .fwd_b(n_fwd_b), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
   );

   // ------------------------------------------------------------------
   // Scoreboard: expectations queued at drive time, popped at sample time
   // ------------------------------------------------------------------
   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   e_stall = 0;
   int   e_nstall = 0;
   int   e_flush = 0;

   function automatic logic [31:0] observe(input string tag);
      case (tag)
         "adv":    return {31'b0, advance};
         "hold":   return {31'b0, hold_front};
         "bub":    return {31'b0, bubble_idex};
         "flush":  return {31'b0, flush_ifid};
         "pcm":    return {31'b0, pcmux_redirect};
         "iread":  return {31'b0, imem_read};
         "dread":  return {31'b0, dmem_read};
         "dwrite": return {31'b0, dmem_write};
         "fa":     return {30'b0, fwd_a};
         "fb":     return {30'b0, fwd_b};
         "stall":  return stall_cnt;
         "fcnt":   return flush_cnt;
         "nadv":   return {31'b0, n_advance};
         "nhold":  return {31'b0, n_hold_front};
         "nbub":   return {31'b0, n_bubble_idex};
         "nfa":    return {30'b0, n_fwd_a};
         "nstall": return {28'b0, n_stall_cnt};
         "nfcnt":  return {28'b0, n_flush_cnt};
         default:  return 'x;
      endcase
   endfunction

   task automatic want(input string tag, input int val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t        e;
      logic [31:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.tag);
         n_tests++;
         assert (o === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue the counter expectations for this cycle, sample, then account
   // for the increments the cycle is expected to cause.
   task automatic fin(input bit s, input bit ns, input bit f);
      want("stall", e_stall);
      want("nstall", e_nstall);
      want("fcnt", e_flush);
      want("nfcnt", e_flush);
      @(negedge clk);
      check_all();
      if (s) e_stall++;
      if (ns && e_nstall != 15) e_nstall++;
      if (f) e_flush++;
   endtask

   task automatic clear_in();
      imem_resp = 0; dmem_resp = 0;
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_we = 0; ex_is_load = 0; ex_redirect = 0;
      mem_rd = 0; mem_we = 0; mem_is_load = 0; mem_is_store = 0;
      wb_rd = 0; wb_we = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset: everything quiet, even with live inputs
      rst = 1'b1;
      clear_in();
      mem_we = 1; mem_rd = 7; ex_rs1 = 7; imem_resp = 1;
      @(negedge clk);
      want("adv", 0); want("iread", 0); want("fa", 0); want("nfa", 0);
      want("bub", 0); want("stall", 0); want("fcnt", 0);
      check_all();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // ---------------- BOOT: no requests, no advance
      clear_in();
      imem_resp = 1; mem_is_load = 1;
      want("adv", 0); want("iread", 0); want("dread", 0);
      fin(0, 0, 0);

      // ---------------- A0: fetch request appears
      tick(); clear_in();
      want("iread", 1); want("adv", 0);
      fin(1, 1, 0);

      // ---------------- lw x5 in EX/MEM: dmem_resp c2, imem_resp c4
      tick(); mem_is_load = 1; mem_we = 1; mem_rd = 5;
      want("dread", 1); want("iread", 1); want("adv", 0);
      fin(1, 1, 0);
      tick(); dmem_resp = 1;
      want("dread", 1); want("adv", 0);
      fin(1, 1, 0);
      tick(); dmem_resp = 0;
      want("dread", 0); want("iread", 1); want("adv", 0);
      fin(1, 1, 0);
      tick(); imem_resp = 1;
      want("adv", 1); want("dread", 0); want("nadv", 1);
      fin(0, 0, 0);

      // ---------------- load-use: ID/EX lw x5, IF/ID add x6,x5,x1
      tick(); clear_in(); imem_resp = 1;
      ex_is_load = 1; ex_we = 1; ex_rd = 5;
      id_use_rs1 = 1; id_rs1 = 5; id_use_rs2 = 1; id_rs2 = 1;
      want("adv", 1); want("hold", 1); want("bub", 1); want("flush", 0); want("nhold", 1);
      fin(1, 1, 0);

      // add now in ID/EX, lw in MEM/WB -> forward from MEM/WB
      tick(); clear_in(); imem_resp = 1;
      ex_we = 1; ex_rd = 6; ex_rs1 = 5; ex_rs2 = 1; wb_rd = 5; wb_we = 1;
      want("fa", 2); want("fb", 0); want("nfa", 0); want("hold", 0); want("adv", 1);
      fin(0, 0, 0);

      // ---------------- redirect beats a pending load-use
      tick(); clear_in(); imem_resp = 1;
      ex_is_load = 1; ex_we = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5; ex_redirect = 1;
      want("adv", 1); want("flush", 1); want("bub", 1); want("hold", 0); want("pcm", 1);
      want("nhold", 0); want("nbub", 1);
      fin(0, 0, 1);
      tick(); clear_in(); imem_resp = 1;
      want("adv", 1); want("pcm", 0); want("flush", 0);
      fin(0, 0, 0);

      // redirect without advance: nothing taken, counts as a stall
      tick(); clear_in(); ex_redirect = 1;
      want("adv", 0); want("pcm", 0); want("flush", 0); want("bub", 0);
      fin(1, 1, 0);
      tick(); clear_in(); imem_resp = 1;
      want("adv", 1);
      fin(0, 0, 0);

      // ---------------- forwarding priority and x0
      tick(); clear_in(); imem_resp = 1;
      mem_rd = 7; wb_rd = 7; mem_we = 1; wb_we = 1; ex_rs1 = 7; ex_rs2 = 7;
      want("fa", 1); want("fb", 1); want("nfa", 0);
      fin(0, 0, 0);
      tick(); clear_in(); imem_resp = 1;
      mem_we = 1; wb_we = 1;
      want("fa", 0); want("fb", 0);
      fin(0, 0, 0);
      tick(); clear_in(); imem_resp = 1;
      wb_rd = 7; wb_we = 1; ex_rs1 = 7; ex_rs2 = 3;
      want("fa", 2); want("fb", 0);
      fin(0, 0, 0);

      // ---------------- no-forwarding RAW: add x3 walks EX/MEM -> MEM/WB -> gone
      tick(); clear_in(); imem_resp = 1;
      mem_rd = 3; mem_we = 1; id_use_rs1 = 1; id_rs1 = 3;
      want("hold", 0); want("bub", 0); want("nhold", 1); want("nbub", 1);
      want("adv", 1); want("nadv", 1);
      fin(0, 1, 0);
      tick(); clear_in(); imem_resp = 1;
      wb_rd = 3; wb_we = 1; id_use_rs1 = 1; id_rs1 = 3;
      want("hold", 0); want("nhold", 1);
      fin(0, 1, 0);
      tick(); clear_in(); imem_resp = 1;
      id_use_rs1 = 1; id_rs1 = 3;
      want("nhold", 0);
      fin(0, 0, 0);
      tick(); clear_in(); imem_resp = 1;
      ex_rd = 3; ex_we = 1; id_use_rs1 = 1; id_rs1 = 3;
      want("hold", 0); want("nhold", 1);
      fin(0, 1, 0);
      tick(); clear_in(); imem_resp = 1;
      ex_we = 1; id_use_rs1 = 1;
      want("nhold", 0);
      fin(0, 0, 0);

      // ---------------- load-use through rs2 only; unused source ignored
      tick(); clear_in(); imem_resp = 1;
      ex_is_load = 1; ex_we = 1; ex_rd = 9; id_rs1 = 9; id_use_rs2 = 1; id_rs2 = 9;
      want("hold", 1); want("bub", 1);
      fin(1, 1, 0);
      tick(); clear_in(); imem_resp = 1;
      ex_is_load = 1; ex_we = 1; ex_rd = 9; id_rs1 = 9; id_rs2 = 9;
      want("hold", 0); want("nhold", 0);
      fin(0, 0, 0);

      // ---------------- idle stalls drive the 4-bit counter into saturation
      for (int k = 0; k < 8; k++) begin
         tick(); clear_in();
         want("adv", 0);
         fin(1, 1, 0);
      end

      // ---------------- store handshake, then reset mid-access
      tick(); clear_in(); mem_is_store = 1; imem_resp = 1;
      want("dwrite", 1); want("dread", 0); want("adv", 0);
      fin(1, 1, 0);
      tick(); clear_in(); mem_is_store = 1; dmem_resp = 1;
      want("adv", 1); want("dwrite", 1);
      fin(0, 0, 0);
      tick(); clear_in(); mem_is_store = 1; dmem_resp = 1;
      want("adv", 0); want("dwrite", 1); want("iread", 1);
      fin(1, 1, 0);
      tick(); clear_in(); mem_is_store = 1;
      want("dwrite", 0); want("iread", 1);
      fin(1, 1, 0);

      #2 rst = 1'b1;
      #1;
      e_stall = 0; e_nstall = 0; e_flush = 0;
      want("dwrite", 0); want("iread", 0); want("adv", 0);
      want("stall", 0); want("nstall", 0); want("fcnt", 0); want("nfcnt", 0);
      check_all();
      @(posedge clk);
      #1 rst = 1'b0;
      want("dwrite", 0); want("iread", 0);
      fin(0, 0, 0);
      tick();
      want("dwrite", 1); want("iread", 1); want("adv", 0);
      fin(1, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
